// File: rtl/tx_slot_scheduler_pkg.sv
// Shared types, requester indices and random-draw constants for the transmit slot scheduler.
// The LFSR seed/taps live here so other random-draw blocks stay in step with this one.
package tx_slot_scheduler_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_SLOT,
        BACKOFF,
        SENSE,
        TX
    } schedState_t;

    localparam int REQ_SOS  = 3;
    localparam int REQ_FWD  = 2;
    localparam int REQ_OWN  = 1;
    localparam int REQ_CTRL = 0;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // One step of the right-shifting Galois LFSR.
    function automatic logic [15:0] lfsrStep(input logic [15:0] cur);
        return cur[0] ? ((cur >> 1) ^ LFSR_TAPS) : (cur >> 1);
    endfunction

    function automatic logic [3:0] pickWinner(input logic [3:0] r);
        logic [3:0] w;
        w = '0;
        if (r[REQ_SOS])       w[REQ_SOS]  = 1'b1;
        else if (r[REQ_FWD])  w[REQ_FWD]  = 1'b1;
        else if (r[REQ_OWN])  w[REQ_OWN]  = 1'b1;
        else if (r[REQ_CTRL]) w[REQ_CTRL] = 1'b1;
        return w;
    endfunction

endpackage

// File: rtl/tx_slot_scheduler_tdma_frame_timer.sv
// TDMA frame timer: cycle-within-slot and slot-within-frame counters, restarted by frameSync.
module tdma_frame_timer #(
    parameter int WORD_WIDTH  = 16,
    parameter int SLOT_CYCLES = 8
) (
    input  logic                             clk,
    input  logic                             nrst,
    input  logic                             frameSync,
    input  logic [WORD_WIDTH-1:0]            frameLen,
    output logic [$clog2(SLOT_CYCLES)-1:0]   slotCyc,
    output logic [WORD_WIDTH-1:0]            slotIdx
);

    localparam int CYC_W = $clog2(SLOT_CYCLES);
    localparam logic [CYC_W-1:0] LAST_CYC = CYC_W'(SLOT_CYCLES - 1);

    logic lastSlot;

    // A zero frame length pins the slot index at 0.
    assign lastSlot = (frameLen == '0) || (slotIdx >= frameLen - WORD_WIDTH'(1));

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            slotCyc <= '0;
            slotIdx <= '0;
        end else if (frameSync) begin
            slotCyc <= '0;
            slotIdx <= '0;
        end else if (slotCyc == LAST_CYC) begin
            slotCyc <= '0;
            slotIdx <= lastSlot ? '0 : slotIdx + WORD_WIDTH'(1);
        end else begin
            slotCyc <= slotCyc + CYC_W'(1);
        end
    end

endmodule

// File: rtl/tx_slot_scheduler.sv
// Transmit slot scheduler: shares the radio between SOS/FWD/OWN/CTRL using backoff+sense or TDMA slots.
// Optional build macro SOS_PREEMPT_EN lets a rising SOS request abort a lower request that is still waiting.
module tx_slot_scheduler
    import tx_slot_scheduler_pkg::*;
#(
    parameter int WORD_WIDTH   = 16,
    parameter int SLOT_CYCLES  = 8,
    parameter int BACKOFF_BITS = 3,
    parameter int MAX_RETRY    = 3,
    parameter int TX_TIMEOUT   = 32
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  phase,
    input  logic [WORD_WIDTH-1:0] myNodeID,
    input  logic [WORD_WIDTH-1:0] myTimeslot,
    input  logic [WORD_WIDTH-1:0] frame_len,
    input  logic                  frame_sync,
    input  logic                  channel_clear,
    input  logic [3:0]            req,
    input  logic                  tx_done,
    output logic [3:0]            grant,
    output logic [3:0]            ack,
    output logic                  tx_fail,
    output logic                  okToSend,
    output logic [WORD_WIDTH-1:0] cur_slot
);

    localparam int CYC_W   = $clog2(SLOT_CYCLES);
    localparam int BO_W    = BACKOFF_BITS + 1;
    localparam int RETRY_W = $clog2(MAX_RETRY + 1);
    localparam int TX_W    = $clog2(TX_TIMEOUT + 1);

    schedState_t          state, nextState;
    logic [3:0]           grantNext, ackNext;
    logic                 failNext;
    logic [BO_W-1:0]      backoffCnt, backoffNext, backoffDraw;
    logic [RETRY_W-1:0]   retryCnt, retryNext;
    logic [TX_W-1:0]      txCnt, txCntNext;
    logic [15:0]          lfsr, nodeMix;
    logic                 unusedMixBits;
    logic [CYC_W-1:0]     slotCyc;
    logic [WORD_WIDTH-1:0] slotIdx;
    logic                 slotHit;
    logic [3:0]           reqEligible, winner;

    tdma_frame_timer #(
        .WORD_WIDTH (WORD_WIDTH),
        .SLOT_CYCLES(SLOT_CYCLES)
    ) frameTimer (
        .clk      (clk),
        .nrst     (nrst),
        .frameSync(frame_sync),
        .frameLen (frame_len),
        .slotCyc  (slotCyc),
        .slotIdx  (slotIdx)
    );

    assign cur_slot = slotIdx;
    assign okToSend = (state == TX);

    // A slot outside the frame never matches, so the request just waits.
    assign slotHit = (slotIdx == myTimeslot) && (slotCyc == '0) && (myTimeslot < frame_len);

    assign nodeMix       = lfsr ^ 16'(myNodeID);
    assign unusedMixBits = ^nodeMix[15:BACKOFF_BITS];
    assign backoffDraw   = BO_W'(nodeMix[BACKOFF_BITS-1:0]) + BO_W'(1);

    // The requester being acked this cycle sits out arbitration until the next cycle.
    assign reqEligible = req & ~ack;
    assign winner      = pickWinner(reqEligible);

`ifdef SOS_PREEMPT_EN
    logic sosReqQ;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) sosReqQ <= 1'b0;
        else       sosReqQ <= req[REQ_SOS];
    end
`endif

    always_comb begin
        nextState   = state;
        grantNext   = grant;
        backoffNext = backoffCnt;
        retryNext   = retryCnt;
        txCntNext   = txCnt;
        ackNext     = '0;
        failNext    = 1'b0;

        case (state)
            IDLE: begin
                if (reqEligible != '0) begin
                    grantNext = winner;
                    retryNext = '0;
                    if (phase && !winner[REQ_SOS]) begin
                        nextState = WAIT_SLOT;
                    end else begin
                        backoffNext = backoffDraw;
                        nextState   = BACKOFF;
                    end
                end
            end
            WAIT_SLOT: begin
                if (!phase) begin
                    grantNext = '0;
                    nextState = IDLE;
                end else if (slotHit) begin
                    nextState = SENSE;
                end
            end
            BACKOFF: begin
                backoffNext = backoffCnt - BO_W'(1);
                if (backoffCnt <= BO_W'(1)) nextState = SENSE;
            end
            SENSE: begin
                if (channel_clear) begin
                    txCntNext = '0;
                    nextState = TX;
                end else if (retryCnt == RETRY_W'(MAX_RETRY - 1)) begin
                    ackNext   = grant;
                    failNext  = 1'b1;
                    grantNext = '0;
                    retryNext = '0;
                    nextState = IDLE;
                end else begin
                    retryNext = retryCnt + RETRY_W'(1);
                    if (!phase || grant[REQ_SOS]) begin
                        backoffNext = backoffDraw;
                        nextState   = BACKOFF;
                    end else begin
                        nextState = WAIT_SLOT;
                    end
                end
            end
            TX: begin
                if (tx_done) begin
                    ackNext   = grant;
                    grantNext = '0;
                    nextState = IDLE;
                end else if (txCnt == TX_W'(TX_TIMEOUT - 1)) begin
                    ackNext   = grant;
                    failNext  = 1'b1;
                    grantNext = '0;
                    nextState = IDLE;
                end else begin
                    txCntNext = txCnt + TX_W'(1);
                end
            end
            default: begin
                grantNext = '0;
                nextState = IDLE;
            end
        endcase

`ifdef SOS_PREEMPT_EN
        // Aborted lower request gets no ack; its level req keeps it pending for the next IDLE.
        if ((state == WAIT_SLOT || state == BACKOFF) && !grant[REQ_SOS] &&
            req[REQ_SOS] && !sosReqQ) begin
            grantNext          = '0;
            grantNext[REQ_SOS] = 1'b1;
            backoffNext        = backoffDraw;
            retryNext          = '0;
            nextState          = BACKOFF;
        end
`endif
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state      <= IDLE;
            grant      <= '0;
            ack        <= '0;
            tx_fail    <= 1'b0;
            backoffCnt <= '0;
            retryCnt   <= '0;
            txCnt      <= '0;
            lfsr       <= LFSR_SEED;
        end else begin
            state      <= nextState;
            grant      <= grantNext;
            ack        <= ackNext;
            tx_fail    <= failNext;
            backoffCnt <= backoffNext;
            retryCnt   <= retryNext;
            txCnt      <= txCntNext;
            lfsr       <= lfsrStep(lfsr);
        end
    end

endmodule

// File: tb/tb_tx_slot_scheduler.sv
// Self-checking bench for tx_slot_scheduler: scoreboard of expected ack/tx_fail pulses plus timing checks.
module tb_tx_slot_scheduler;
    import tx_slot_scheduler_pkg::*;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        phase = 1'b0;
    logic [15:0] myNodeID = 16'h0005;
    logic [15:0] myTimeslot = 16'd2;
    logic [15:0] frame_len = 16'd4;
    logic        frame_sync = 1'b0;
    logic        channel_clear = 1'b1;
    logic [3:0]  req = 4'b0;
    logic        tx_done = 1'b0;
    logic [3:0]  grant, ack;
    logic        tx_fail, okToSend;
    logic [15:0] cur_slot;

    typedef struct {
        logic [3:0] ackVec;
        logic       fail;
    } expect_t;

    expect_t expQ[$];
    int compCount = 0;
    int failCount = 0;

    tx_slot_scheduler dut (
        .clk          (clk),
        .nrst         (nrst),
        .phase        (phase),
        .myNodeID     (myNodeID),
        .myTimeslot   (myTimeslot),
        .frame_len    (frame_len),
        .frame_sync   (frame_sync),
        .channel_clear(channel_clear),
        .req          (req),
        .tx_done      (tx_done),
        .grant        (grant),
        .ack          (ack),
        .tx_fail      (tx_fail),
        .okToSend     (okToSend),
        .cur_slot     (cur_slot)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [3:0] modelPrio(input logic [3:0] r);
        logic [3:0] w;
        w = '0;
        for (int i = 3; i >= 0; i--) begin
            if (r[i] && w == '0) w[i] = 1'b1;
        end
        return w;
    endfunction

    task automatic pushExp(input logic [3:0] a, input logic f);
        expect_t e;
        e.ackVec = a;
        e.fail   = f;
        expQ.push_back(e);
    endtask

    // Scoreboard consumer: every ack/tx_fail pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (nrst && (ack != 4'b0 || tx_fail)) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpectedPulse", {27'b0, ack, tx_fail}, 32'b0);
            end else begin
                expect_t e;
                e = expQ.pop_front();
                checkOutput("ackVec", {28'b0, ack}, {28'b0, e.ackVec});
                checkOutput("ackFail", {31'b0, tx_fail}, {31'b0, e.fail});
            end
        end
    end

    task automatic applyStimulus(input logic ph, input logic clr, input logic [3:0] r);
        phase         = ph;
        channel_clear = clr;
        req           = r;
    endtask

    task automatic waitOk(input string tag, input int budget, output int cyc);
        cyc = 0;
        while (!okToSend && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput(tag, {31'b0, okToSend}, 32'd1);
    endtask

    task automatic waitAck(input string tag, input int budget);
        int n;
        n = 0;
        while (ack == 4'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, {31'b0, (ack != 4'b0)}, 32'd1);
        req = req & ~ack;
    endtask

    task automatic pulseDone();
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cyc, senseCount, n;
        logic okSeen;
        logic [3:0] order[3];
        logic [3:0] remaining;

        // Reset values
        repeat (3) @(negedge clk);
        checkOutput("rstGrant", {28'b0, grant}, 32'd0);
        checkOutput("rstAck", {28'b0, ack}, 32'd0);
        checkOutput("rstFail", {31'b0, tx_fail}, 32'd0);
        checkOutput("rstOk", {31'b0, okToSend}, 32'd0);
        checkOutput("rstSlot", {16'b0, cur_slot}, 32'd0);
        nrst = 1'b1;
        repeat (2) @(negedge clk);

        // Setup phase, contention access, clean completion
        applyStimulus(1'b0, 1'b1, 4'b0001);
        pushExp(4'b0001, 1'b0);
        waitOk("t1Ok", 20, cyc);
        checkOutput("t1OkWindow", {31'b0, (cyc >= 3 && cyc <= 10)}, 32'd1);
        checkOutput("t1Grant", {28'b0, grant}, 32'b0001);
        repeat (3) @(negedge clk);
        checkOutput("t1OkHeld", {31'b0, okToSend}, 32'd1);
        pulseDone();
        waitAck("t1Ack", 5);
        checkOutput("t1OkLow", {31'b0, okToSend}, 32'd0);
        checkOutput("t1GrantClr", {28'b0, grant}, 32'd0);
        repeat (2) @(negedge clk);

        // TDMA: slot 2 of a 4-slot frame, 8 cycles per slot
        phase      = 1'b1;
        frame_len  = 16'd4;
        myTimeslot = 16'd2;
        req        = 4'b0010;
        frame_sync = 1'b1;
        pushExp(4'b0010, 1'b0);
        @(negedge clk);
        frame_sync = 1'b0;
        cyc = 0;
        while (!okToSend && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("t2OkEdge", cyc, 32'd18);
        checkOutput("t2Slot", {16'b0, cur_slot}, 32'd2);
        checkOutput("t2Grant", {28'b0, grant}, 32'b0010);
        pulseDone();
        waitAck("t2Ack", 5);
        phase = 1'b0;
        repeat (2) @(negedge clk);

        // Busy channel: three sense attempts then drop
        applyStimulus(1'b0, 1'b0, 4'b0001);
        pushExp(4'b0001, 1'b1);
        senseCount = 0;
        okSeen = 1'b0;
        n = 0;
        while (ack == 4'b0 && n < 120) begin
            @(negedge clk);
            n++;
            if (dut.state == SENSE) senseCount++;
            if (okToSend) okSeen = 1'b1;
        end
        checkOutput("t3AckSeen", {31'b0, (ack != 4'b0)}, 32'd1);
        checkOutput("t3FailPulse", {31'b0, tx_fail}, 32'd1);
        req = req & ~ack;
        checkOutput("t3Senses", senseCount, 32'd3);
        checkOutput("t3NoOk", {31'b0, okSeen}, 32'd0);
        channel_clear = 1'b1;
        repeat (2) @(negedge clk);

        // Simultaneous requests served in priority order
        applyStimulus(1'b0, 1'b1, 4'b1110);
        remaining = 4'b1110;
        for (int i = 0; i < 3; i++) begin
            order[i] = modelPrio(remaining);
            remaining = remaining & ~order[i];
            pushExp(order[i], 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            waitOk("t4Ok", 20, cyc);
            checkOutput("t4Grant", {28'b0, grant}, {28'b0, order[i]});
            pulseDone();
            waitAck("t4Ack", 5);
        end
        repeat (2) @(negedge clk);

        // TX timeout when tx_done never comes
        applyStimulus(1'b0, 1'b1, 4'b0100);
        pushExp(4'b0100, 1'b1);
        waitOk("t5Ok", 20, cyc);
        n = 0;
        while (ack == 4'b0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        checkOutput("t5TimeoutCycles", n, 32'd32);
        checkOutput("t5OkFell", {31'b0, okToSend}, 32'd0);
        req = req & ~ack;
        repeat (2) @(negedge clk);

        // Asynchronous reset in the middle of TX, then re-service
        applyStimulus(1'b0, 1'b1, 4'b0001);
        waitOk("t6Ok", 20, cyc);
        #2 nrst = 1'b0;
        #1;
        checkOutput("t6RstOk", {31'b0, okToSend}, 32'd0);
        checkOutput("t6RstGrant", {28'b0, grant}, 32'd0);
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        pushExp(4'b0001, 1'b0);
        waitOk("t6Reserve", 20, cyc);
        checkOutput("t6Grant", {28'b0, grant}, 32'b0001);
        pulseDone();
        waitAck("t6Ack", 5);
        repeat (2) @(negedge clk);

`ifdef SOS_PREEMPT_EN
        // SOS preempts an OWN request waiting for its slot
        phase      = 1'b1;
        myTimeslot = 16'd3;
        req        = 4'b0010;
        frame_sync = 1'b1;
        @(negedge clk);
        frame_sync = 1'b0;
        repeat (3) @(negedge clk);
        req = 4'b1010;
        pushExp(4'b1000, 1'b0);
        pushExp(4'b0010, 1'b0);
        @(negedge clk);
        checkOutput("t6PreemptGrant", {28'b0, grant}, 32'b1000);
        waitOk("t6SosOk", 20, cyc);
        pulseDone();
        waitAck("t6SosAck", 5);
        waitOk("t6OwnOk", 80, cyc);
        checkOutput("t6OwnGrant", {28'b0, grant}, 32'b0010);
        pulseDone();
        waitAck("t6OwnAck", 5);
        phase = 1'b0;
        repeat (2) @(negedge clk);
`endif

        // Frame counter wrap and frame_len=0 freeze
        frame_len  = 16'd4;
        frame_sync = 1'b1;
        @(negedge clk);
        frame_sync = 1'b0;
        checkOutput("t7SlotStart", {16'b0, cur_slot}, 32'd0);
        repeat (24) @(negedge clk);
        checkOutput("t7SlotLast", {16'b0, cur_slot}, 32'd3);
        repeat (8) @(negedge clk);
        checkOutput("t7SlotWrap", {16'b0, cur_slot}, 32'd0);
        frame_len = 16'd0;
        repeat (20) @(negedge clk);
        checkOutput("t7Frozen", {16'b0, cur_slot}, 32'd0);
        frame_len = 16'd4;

        repeat (3) @(negedge clk);
        checkOutput("scoreboardDrained", expQ.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, failCount);
        $finish;
    end

endmodule
